countdown16_reload_timer: RTL and testbench
===========================================

// Module: countdown16_reload_timer
// PURPOSE
//  Loadable 16-bit down-counting timer with one-shot and periodic (auto-reload) modes.
//  - Counts down from a software-loaded value and flags terminal count (TC) with a one-cycle pulse.
//  - Complements the free-running up counters in simple_registers/counters.
//  - Sits between a register-write port (load handshake) and event logic consuming tc_pulse.
// PARAMETERS
//  WIDTH       16    counter, reload and load_value width in bits
//  TC_HOLD     0     1: in one-shot mode, tc_level stays high until the next load/start; 0: tc_level unused (held 0)
// PORTS
//  clock0      in   1      single clock, all state updates on posedge
//  reset       in   1      reset, asynchronous, active-low (clears all state immediately)
//  load_valid  in   1      load request; value on load_value
//  load_value  in   WIDTH  reload value to latch
//  load_ready  out  1      high when a load can be accepted (= !busy)
//  start       in   1      begin counting (level sampled per cycle; effective only in IDLE)
//  stop        in   1      abort counting; returns to IDLE, count holds
//  periodic    in   1      1 = auto-reload on TC; 0 = one-shot; sampled at start, held in mode_q
//  tick        in   1      count enable; one decrement per cycle with tick=1
//  count       out  WIDTH  current counter value
//  busy        out  1      high while in RUN
//  tc_pulse    out  1      registered one-cycle pulse at terminal count
//  tc_level    out  1      sticky TC flag (see TC_HOLD)
// BEHAVIOUR
//  Reset (reset=0, async):
//  - count=0, reload_q=0, mode_q=0, busy=0, tc_pulse=0, tc_level=0, state=IDLE.
//  - Reset mid-RUN aborts immediately. No pending event survives reset.
//  States: IDLE, RUN (1-bit state, encoded in package).
//  Load handshake:
//  - Accepted on the edge where load_valid && load_ready.
//  - Next cycle: reload_q=load_value, count=load_value, tc_level=0.
//  - While busy, load_ready=0; load_valid is ignored and not queued.
//  IDLE:
//  - start=1 && stop=0 -> next cycle state=RUN, busy=1, mode_q=periodic, count=reload_q, tc_level=0.
//  - start and stop together: stop wins; stays IDLE.
//  - Load and start in the same cycle: load applies first; count=load_value on entering RUN.
//  RUN, on each edge:
//  - stop=1: state=IDLE, busy=0, count holds, no tc_pulse (stop has priority over tick).
//  - tick=1 && count!=0: count=count-1.
//  - tick=1 && count==0 (terminal count): tc_pulse=1 on the next cycle only; tc_level=TC_HOLD & ~mode_q.
//    - mode_q=1: count=reload_q, stay RUN.
//    - mode_q=0: state=IDLE, busy=0, count stays 0.
//  - tick=0: count and state hold; tc_pulse=0.
//  Timing and arithmetic:
//  - Period = reload_q+1 ticks. reload_q=0 in periodic mode gives tc_pulse on every tick.
//  - No underflow: count never wraps past 0; decrement only when count!=0. Unsigned, WIDTH bits.
//  - tc_pulse is never high for two consecutive cycles unless periodic with reload_q=0 and tick held high.
//  - start held high in RUN has no effect; it restarts only after return to IDLE.
// STRUCTURE
//  - Package countdown16_pkg: state encoding ST_IDLE/ST_RUN, WIDTH default constant.
//  - Sub-module counterdown16_core: WIDTH-bit register with async active-low clear, synchronous load
//    (load_en, load_val), decrement enable (dec_en), zero flag output.
//  - Top holds FSM, reload_q, mode_q, tc_pulse/tc_level registers and load handshake.
// TESTING
//  1. Reset: drive reset=0 mid-run with count=16'h0123 -> same-cycle count=0, busy=0, tc_pulse=0, load_ready=1.
//  2. One-shot: load 3, start, periodic=0, tick=1 constant -> count 3,2,1,0;
//     tc_pulse on cycle 5 after start; busy falls with it; count stays 0.
//  3. Periodic: load 2, periodic=1, tick=1 -> tc_pulse every 3rd cycle, count sequence 2,1,0,2,1,0; busy stays 1.
//  4. Gated tick: load 4, tick every other cycle -> tc_pulse after exactly 5 ticks (10 cycles); count holds on tick=0.
//  5. Stop and load-while-busy:
//     - load_valid with 16'hBEEF while RUN -> load_ready=0, reload_q unchanged.
//     - stop+tick same cycle at count=7 -> IDLE, count=7, no tc_pulse.
//  6. Edge values:
//     - load 0, periodic=1 -> tc_pulse every ticked cycle.
//     - load 16'hFFFF -> first decrement gives 16'hFFFE; start+stop together -> stays IDLE.

Source files
------------

// File: rtl/countdown16_pkg.sv
// countdown16_pkg: shared state encoding and default width for the countdown timer
package countdown16_pkg;
  localparam int WIDTH = 16;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
endpackage

// File: rtl/counterdown16_core.sv
// counterdown16_core: loadable down counter that saturates at zero
module counterdown16_core #(
  parameter int WIDTH = countdown16_pkg::WIDTH
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec_en,
  output logic [WIDTH-1:0] count,
  output logic             zero
);
  import countdown16_pkg::*;
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = load_en ? load_val : (dec_en && count_q != '0) ? count_q - WIDTH'(1) : count_q;
  always_ff @(posedge clock0 or negedge reset)
    if (!reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
  assign zero = count_q == '0;
endmodule

// File: rtl/countdown16_reload_timer.sv
// countdown16_reload_timer: loadable down timer with one-shot and auto-reload modes
module countdown16_reload_timer #(
  parameter int WIDTH = countdown16_pkg::WIDTH,
  parameter bit TC_HOLD = 1'b0
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             tc_level
);
  import countdown16_pkg::*;
  logic [0:0] state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic mode_q, mode_d, tc_pulse_q, tc_pulse_d, tc_level_q, tc_level_d;
  logic idle, load_acc, go, tc, zero;
  always_comb begin
    idle = state_q == ST_IDLE;
    load_acc = load_valid && idle;
    go = idle && start && !stop;
    tc = !idle && !stop && tick && zero;
    reload_d = load_acc ? load_value : reload_q;
    state_d = go ? ST_RUN : (!idle && (stop || (tc && !mode_q))) ? ST_IDLE : state_q;
    mode_d = go ? periodic : mode_q;
    tc_pulse_d = tc;
    tc_level_d = (load_acc || go) ? 1'b0 : tc ? (TC_HOLD && !mode_q) : tc_level_q;
  end
  always_ff @(posedge clock0 or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      reload_q <= '0;
      mode_q <= 1'b0;
      tc_pulse_q <= 1'b0;
      tc_level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reload_q <= reload_d;
      mode_q <= mode_d;
      tc_pulse_q <= tc_pulse_d;
      tc_level_q <= tc_level_d;
    end
  // reload_d already reflects a same-cycle load, so one mux serves load, start and auto-reload
  counterdown16_core #(.WIDTH(WIDTH)) u_core (
    .clock0  (clock0),
    .reset   (reset),
    .load_en (load_acc || go || (tc && mode_q)),
    .load_val(reload_d),
    .dec_en  (!idle && !stop && tick),
    .count   (count),
    .zero    (zero)
  );
  assign load_ready = idle;
  assign busy = !idle;
  assign tc_pulse = tc_pulse_q;
  assign tc_level = tc_level_q;
endmodule

// File: tb/tb_countdown16_reload_timer.sv
// tb_countdown16_reload_timer: scoreboard bench for the countdown reload timer
module tb_countdown16_reload_timer;
  localparam bit TCH = 1'b1;
  logic clock0 = 1'b0;
  logic reset = 1'b0;
  logic load_valid = 1'b0, start = 1'b0, stop = 1'b0, periodic = 1'b0, tick = 1'b0;
  logic [15:0] load_value = '0;
  logic load_ready, busy, tc_pulse, tc_level;
  logic [15:0] count;
  int total = 0, bad = 0;
  typedef struct {logic [15:0] c; logic b, p, l, r;} exp_t;
  exp_t exp_q[$];
  logic [15:0] m_count, m_reload;
  logic m_mode, m_busy, m_pulse, m_level;

  countdown16_reload_timer #(.WIDTH(16), .TC_HOLD(TCH)) dut (
    .clock0(clock0), .reset(reset), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready), .start(start), .stop(stop), .periodic(periodic), .tick(tick),
    .count(count), .busy(busy), .tc_pulse(tc_pulse), .tc_level(tc_level)
  );

  always #5 clock0 = ~clock0;

  always @(posedge clock0) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if ({count, busy, tc_pulse, tc_level, load_ready} !== {e.c, e.b, e.p, e.l, e.r}) begin
        bad++;
        $display("FAIL scoreboard t=%0t count=%h busy=%b pulse=%b level=%b ready=%b exp count=%h busy=%b pulse=%b level=%b ready=%b",
                 $time, count, busy, tc_pulse, tc_level, load_ready, e.c, e.b, e.p, e.l, e.r);
      end
    end
  end

  task automatic mreset();
    m_count = '0; m_reload = '0; m_mode = 0; m_busy = 0; m_pulse = 0; m_level = 0;
  endtask

  task automatic cyc(input logic lv, input logic [15:0] lval, input logic st, sp, per, tk);
    logic [15:0] nc, nr;
    logic nm, nb, np, nl;
    exp_t e;
    load_valid = lv; load_value = lval; start = st; stop = sp; periodic = per; tick = tk;
    nc = m_count; nr = m_reload; nm = m_mode; nb = m_busy; np = 0; nl = m_level;
    if (!m_busy) begin
      if (lv) begin nr = lval; nc = lval; nl = 0; end
      if (st && !sp) begin nb = 1; nm = per; nc = nr; nl = 0; end
    end else if (sp) nb = 0;
    else if (tk) begin
      if (m_count != 0) nc = m_count - 16'd1;
      else begin
        np = 1;
        nl = TCH && !m_mode;
        if (m_mode) nc = m_reload; else nb = 0;
      end
    end
    m_count = nc; m_reload = nr; m_mode = nm; m_busy = nb; m_pulse = np; m_level = nl;
    e.c = nc; e.b = nb; e.p = np; e.l = nl; e.r = !nb;
    exp_q.push_back(e);
    @(posedge clock0);
    #2;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({count, busy, tc_pulse, tc_level, load_ready} !== {16'h0, 4'b0001}) begin
      bad++; $display("FAIL reset_init got=%h/%b%b%b%b", count, busy, tc_pulse, tc_level, load_ready);
    end
    mreset();
    #11 reset = 1'b1;
    cyc(1, 16'h0123, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    total++;
    if (count !== 16'h0123 || busy !== 1'b1) begin
      bad++; $display("FAIL reset_prerun count=%h busy=%b want 0123/1", count, busy);
    end
    #3 reset = 1'b0;
    #1;
    total++;
    if ({count, busy, tc_pulse, load_ready} !== {16'h0, 3'b001}) begin
      bad++; $display("FAIL reset_async count=%h busy=%b pulse=%b ready=%b want 0000/0/0/1", count, busy, tc_pulse, load_ready);
    end
    mreset();
    #2 reset = 1'b1;
    #4;
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    total++;
    if (tc_pulse !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_reload_cleared pulse=%b busy=%b want 1/0", tc_pulse, busy);
    end
  endtask

  task automatic test_oneshot();
    cyc(1, 16'd3, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (count !== 16'(3 - i) || tc_pulse !== 1'b0) begin
        bad++; $display("FAIL oneshot_seq%0d count=%h pulse=%b want %h/0", i, count, tc_pulse, 16'(3 - i));
      end
      cyc(0, 0, 0, 0, 0, 1);
    end
    total++;
    if ({count, busy, tc_pulse, tc_level} !== {16'h0, 3'b011}) begin
      bad++; $display("FAIL oneshot_tc count=%h busy=%b pulse=%b level=%b want 0000/0/1/1", count, busy, tc_pulse, tc_level);
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 16'd9, 0, 0, 0, 0);
    total++;
    if (tc_level !== 1'b0 || count !== 16'd9) begin
      bad++; $display("FAIL level_clear level=%b count=%h want 0/0009", tc_level, count);
    end
  endtask

  task automatic test_periodic();
    int pulses = 0;
    cyc(1, 16'd2, 1, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      total++;
      if (count !== 16'(2 - ((i + 1) % 3)) || busy !== 1'b1 || tc_pulse !== (i % 3 == 2)) begin
        bad++; $display("FAIL periodic_cyc%0d count=%h busy=%b pulse=%b", i, count, busy, tc_pulse);
      end
      pulses += int'(tc_pulse);
    end
    total++;
    if (pulses != 3) begin
      bad++; $display("FAIL periodic_pulses got=%0d want 3", pulses);
    end
    cyc(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_gated_tick();
    cyc(1, 16'd4, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0, i[0]);
      total++;
      if (tc_pulse !== (i == 9) || (i < 9 && count !== 16'(4 - (i + 1) / 2))) begin
        bad++; $display("FAIL gated_cyc%0d count=%h pulse=%b", i, count, tc_pulse);
      end
    end
  endtask

  task automatic test_stop_and_busy_load();
    cyc(1, 16'd10, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 16'hBEEF, 0, 0, 0, 0);
    total++;
    if (load_ready !== 1'b0 || count !== 16'd7) begin
      bad++; $display("FAIL busy_load ready=%b count=%h want 0/0007", load_ready, count);
    end
    cyc(0, 0, 0, 1, 0, 1);
    total++;
    if ({count, busy, tc_pulse} !== {16'd7, 2'b00}) begin
      bad++; $display("FAIL stop_tick count=%h busy=%b pulse=%b want 0007/0/0", count, busy, tc_pulse);
    end
    cyc(0, 0, 1, 0, 0, 0);
    total++;
    if (count !== 16'd10) begin
      bad++; $display("FAIL reload_kept count=%h want 000a", count);
    end
    cyc(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_edges();
    cyc(1, 16'd0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      total++;
      if (tc_pulse !== 1'b1 || count !== 16'd0 || busy !== 1'b1) begin
        bad++; $display("FAIL zero_periodic%0d pulse=%b count=%h busy=%b want 1/0000/1", i, tc_pulse, count, busy);
      end
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 16'hFFFF, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    total++;
    if (count !== 16'hFFFE) begin
      bad++; $display("FAIL max_dec count=%h want fffe", count);
    end
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 1);
    total++;
    if (busy !== 1'b0 || count !== 16'hFFFE) begin
      bad++; $display("FAIL start_stop busy=%b count=%h want 0/fffe", busy, count);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 16'd1, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    total++;
    if (tc_pulse !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_tc pulse=%b busy=%b want 1/0", tc_pulse, busy);
    end
    cyc(0, 0, 1, 0, 0, 1);
    total++;
    if (busy !== 1'b1 || count !== 16'd1 || tc_pulse !== 1'b0) begin
      bad++; $display("FAIL b2b_restart busy=%b count=%h pulse=%b want 1/0001/0", busy, count, tc_pulse);
    end
    cyc(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_gated_tick();
    test_stop_and_busy_load();
    test_edges();
    test_back_to_back();
    repeat (2) @(posedge clock0);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
